// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Definitions shared by the DES region sequencer and the DES wrapper:
// the wrapper command codes, the sequencer state encoding and the
// widths of the region and counter values.
// No ports.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int REGION_W  = 32;
    localparam int COUNTER_W = 64;
    localparam int CMD_W     = 32;

    localparam logic [CMD_W-1:0] CMD_READ_REGION = 32'd0;
    localparam logic [CMD_W-1:0] CMD_START       = 32'd1;
    localparam logic [CMD_W-1:0] CMD_RESTART     = 32'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REG_REQ,
        ST_REG_REL,
        ST_START_REQ,
        ST_START_REL,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_RST_REQ,
        ST_RST_REL,
        ST_PUSH,
        ST_NEXT
    } seq_state_t;

endpackage

// File: rtl/des_region_sequencer_if.sv
// -----------------------------------------------------------------------------
// des_region_sequencer_if
// Command bus between the region sequencer (master) and the DES wrapper
// (slave).
//   cmd              command code (des_pkg CMD_*)
//   cmd_valid        command offered to the wrapper
//   cmd_read         wrapper acknowledge (four-phase handshake)
//   region           region the wrapper should operate on
//   advance_test_cmd unused wrapper control, held low by the sequencer
//   done             wrapper finished, held while finished
//   counter          wrapper counter register
// -----------------------------------------------------------------------------
interface des_region_sequencer_if;
    import des_pkg::*;

    logic [CMD_W-1:0]     cmd;
    logic                 cmd_valid;
    logic                 cmd_read;
    logic [REGION_W-1:0]  region;
    logic                 advance_test_cmd;
    logic                 done;
    logic [COUNTER_W-1:0] counter;

    modport master (
        output cmd, cmd_valid, region, advance_test_cmd,
        input  cmd_read, done, counter
    );

    modport slave (
        input  cmd, cmd_valid, region, advance_test_cmd,
        output cmd_read, done, counter
    );

endinterface

// File: rtl/des_region_sequencer.sv
// -----------------------------------------------------------------------------
// des_region_sequencer
// Walks a host-supplied inclusive range of regions through the DES wrapper:
// for each region it issues READ_REGION, START, waits for done, captures the
// wrapper counter, issues RESTART and hands the result to the host.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   cfg_valid/cfg_ready           host offers region_first..region_last
//   abort                         stop after the region in progress
//   busy                          any state other than IDLE
//   res_valid/res_ready           result handshake, res_region/res_counter
//   err                           one-cycle pulse: bad range or timeout
//   wrap                          command bus to the wrapper (master side)
//
// Optional feature: define DES_SEQ_TIMEOUT_EN to bound every wrapper
// handshake state to CMD_TIMEOUT cycles; on expiry err pulses, cmd_valid
// drops and the sequencer returns to IDLE.
// -----------------------------------------------------------------------------
module des_region_sequencer
    import des_pkg::*;
#(
    parameter int CMD_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [REGION_W-1:0]   region_first,
    input  logic [REGION_W-1:0]   region_last,
    input  logic                  abort,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [REGION_W-1:0]   res_region,
    output logic [COUNTER_W-1:0]  res_counter,
    output logic                  err,
    des_region_sequencer_if.master wrap
);

    seq_state_t          state;
    logic [REGION_W-1:0] cur;
    logic [REGION_W-1:0] range_last;
    logic [CMD_W-1:0]    cmd_code;
    logic                cmd_on;
    logic                abort_flag;

    assign wrap.cmd              = cmd_code;
    assign wrap.cmd_valid        = cmd_on;
    assign wrap.region           = cur;
    assign wrap.advance_test_cmd = 1'b0;

`ifdef DES_SEQ_TIMEOUT_EN
    logic [31:0] wd;
    logic        timed;
    logic        hs_move;

    // Handshake states are timed; hs_move marks the cycle the state is left.
    always_comb begin
        timed   = 1'b0;
        hs_move = 1'b0;
        case (state)
            ST_REG_REQ, ST_START_REQ, ST_RST_REQ: begin
                timed   = 1'b1;
                hs_move = wrap.cmd_read;
            end
            ST_REG_REL, ST_START_REL, ST_RST_REL: begin
                timed   = 1'b1;
                hs_move = !wrap.cmd_read;
            end
            default: ;
        endcase
    end
`else
    // CMD_TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^CMD_TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur         <= '0;
            range_last  <= '0;
            cmd_code    <= '0;
            cmd_on      <= 1'b0;
            res_valid   <= 1'b0;
            res_region  <= '0;
            res_counter <= '0;
            err         <= 1'b0;
            abort_flag  <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
`ifdef DES_SEQ_TIMEOUT_EN
            wd          <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (busy && abort) abort_flag <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // Clearing here also drops an abort seen alongside cfg_valid.
                    abort_flag <= 1'b0;
                    if (cfg_valid && cfg_ready) begin
                        if (region_first <= region_last) begin
                            cur        <= region_first;
                            range_last <= region_last;
                            cmd_code   <= CMD_READ_REGION;
                            cmd_on     <= 1'b1;
                            busy       <= 1'b1;
                            cfg_ready  <= 1'b0;
                            state      <= ST_REG_REQ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_REG_REQ: if (wrap.cmd_read) begin
                    cmd_on <= 1'b0;
                    state  <= ST_REG_REL;
                end
                ST_REG_REL: if (!wrap.cmd_read) begin
                    cmd_code <= CMD_START;
                    cmd_on   <= 1'b1;
                    state    <= ST_START_REQ;
                end
                ST_START_REQ: if (wrap.cmd_read) begin
                    cmd_on <= 1'b0;
                    state  <= ST_START_REL;
                end
                ST_START_REL: if (!wrap.cmd_read) state <= ST_WAIT_DONE;
                // The wrapper counter settles one cycle after done rises, so
                // sampling is deferred to CAPTURE.
                ST_WAIT_DONE: if (wrap.done) state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    res_counter <= wrap.counter;
                    res_region  <= cur;
                    cmd_code    <= CMD_RESTART;
                    cmd_on      <= 1'b1;
                    state       <= ST_RST_REQ;
                end
                ST_RST_REQ: if (wrap.cmd_read) begin
                    cmd_on <= 1'b0;
                    state  <= ST_RST_REL;
                end
                ST_RST_REL: if (!wrap.cmd_read) begin
                    res_valid <= 1'b1;
                    state     <= ST_PUSH;
                end
                ST_PUSH: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= ST_NEXT;
                end
                ST_NEXT: begin
                    // cur==range_last also covers the all-ones region, so cur never wraps.
                    if (abort_flag || abort || cur == range_last) begin
                        abort_flag <= 1'b0;
                        busy       <= 1'b0;
                        cfg_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        cur      <= cur + 32'd1;
                        cmd_code <= CMD_READ_REGION;
                        cmd_on   <= 1'b1;
                        state    <= ST_REG_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase

`ifdef DES_SEQ_TIMEOUT_EN
            // wd counts completed cycles in the current handshake state.
            if (timed && !hs_move) begin
                if (wd == 32'(CMD_TIMEOUT - 1)) begin
                    err        <= 1'b1;
                    cmd_on     <= 1'b0;
                    abort_flag <= 1'b0;
                    busy       <= 1'b0;
                    cfg_ready  <= 1'b1;
                    state      <= ST_IDLE;
                    wd         <= '0;
                end else begin
                    wd <= wd + 32'd1;
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_des_region_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_region_sequencer
// Directed bench for des_region_sequencer with a behavioural DES wrapper:
// the wrapper acknowledges commands, raises done 20 cycles after START and
// updates its counter one cycle after done. Counter value per region is
// {32'hC0DE0000, region} ^ 64'h5A5A5A5A.
// Build with DES_SEQ_TIMEOUT_EN to exercise the handshake watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_des_region_sequencer;
    import des_pkg::*;

    localparam int DONE_LAT = 20;

    logic        clk = 1'b0;
    logic        rst_n, cfg_valid, cfg_ready, abort, busy;
    logic        res_valid, res_ready, err;
    logic [31:0] region_first, region_last, res_region;
    logic [63:0] res_counter;
    logic        stuck;

    int checks   = 0;
    int failures = 0;
    int n_res    = 0;
    int n_err    = 0;
    logic cmd_seen = 1'b0;

    always #5 clk = ~clk;

    des_region_sequencer_if wrap_bus();

    des_region_sequencer #(.CMD_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .region_first (region_first),
        .region_last  (region_last),
        .abort        (abort),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_region   (res_region),
        .res_counter  (res_counter),
        .err          (err),
        .wrap         (wrap_bus)
    );

    // Behavioural wrapper, driven on the falling edge.
    initial begin
        int          cnt;
        logic        running, pend;
        logic [31:0] m_region;
        cnt = 0; running = 1'b0; pend = 1'b0; m_region = '0;
        wrap_bus.cmd_read = 1'b0;
        wrap_bus.done     = 1'b0;
        wrap_bus.counter  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; running = 1'b0; pend = 1'b0; m_region = '0;
                wrap_bus.cmd_read = 1'b0;
                wrap_bus.done     = 1'b0;
                wrap_bus.counter  = '0;
            end else begin
                if (pend) begin
                    wrap_bus.counter = {32'hC0DE_0000, m_region} ^ 64'h5A5A_5A5A;
                    pend = 1'b0;
                end
                if (running) begin
                    cnt++;
                    if (cnt == DONE_LAT) begin
                        wrap_bus.done = 1'b1;
                        running = 1'b0;
                        pend = 1'b1;
                    end
                end
                if (wrap_bus.cmd_valid && !wrap_bus.cmd_read && !stuck) begin
                    case (wrap_bus.cmd)
                        CMD_READ_REGION: m_region = wrap_bus.region;
                        CMD_START:       begin running = 1'b1; cnt = 0; end
                        CMD_RESTART:     begin
                            wrap_bus.done    = 1'b0;
                            wrap_bus.counter = 64'hBAD0_0000_0000_0BAD;
                        end
                        default: ;
                    endcase
                end
                wrap_bus.cmd_read = stuck ? 1'b0 : wrap_bus.cmd_valid;
            end
        end
    end

    // Event monitor: sees the values the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (res_valid && res_ready) n_res++;
            if (err) n_err++;
            if (wrap_bus.cmd_valid) cmd_seen = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cfg(input logic [31:0] first, input logic [31:0] last);
        region_first = first;
        region_last  = last;
        cfg_valid    = 1'b1;
        @(negedge clk);
        cfg_valid    = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] er, input logic [63:0] ec);
        int n;
        @(negedge clk);
        n = 1;
        while (res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_region"}, 64'(res_region), 64'(er));
        chk({tag, "_counter"}, res_counter, ec);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        @(negedge clk);
        n = 1;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base;
        int e0;
        int n;
        int bad;
        rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; res_ready = 1'b1;
        region_first = '0; region_last = '0; stuck = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd0);
        chk("rst_cmd", 64'(wrap_bus.cmd), 64'd0);
        chk("rst_region", 64'(wrap_bus.region), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_region", 64'(res_region), 64'd0);
        chk("rst_res_counter", res_counter, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_adv", 64'(wrap_bus.advance_test_cmd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cfg_ready", 64'(cfg_ready), 64'd1);

        // Range 5..7
        base = n_res;
        start_cfg(32'd5, 32'd7);
        chk("r57_busy", 64'(busy), 64'd1);
        chk("r57_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("r57_region", 64'(wrap_bus.region), 64'd5);
        chk("r57_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd1);
        chk("r57_cmd", 64'(wrap_bus.cmd), 64'd0);
        wait_result("r57_5", 32'd5, 64'hC0DE_0000_5A5A_5A5F);
        wait_result("r57_6", 32'd6, 64'hC0DE_0000_5A5A_5A5C);
        wait_result("r57_7", 32'd7, 64'hC0DE_0000_5A5A_5A5D);
        wait_idle("r57");
        chk("r57_count", 64'(n_res - base), 64'd3);
        chk("r57_cfg_ready_end", 64'(cfg_ready), 64'd1);

        // Bad range 9..3
        e0 = n_err;
        cmd_seen = 1'b0;
        start_cfg(32'd9, 32'd3);
        chk("bad_err_pulse", 64'(err), 64'd1);
        chk("bad_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("bad_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("bad_err_drop", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        chk("bad_err_count", 64'(n_err - e0), 64'd1);
        chk("bad_no_cmd", 64'(cmd_seen), 64'd0);

        // Single all-ones region
        base = n_res;
        start_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("ones", 32'hFFFF_FFFF, 64'hC0DE_0000_A5A5_A5A5);
        wait_idle("ones");
        chk("ones_count", 64'(n_res - base), 64'd1);
        chk("ones_no_wrap", 64'(wrap_bus.region), 64'hFFFF_FFFF);

        // Abort during WAIT_DONE of region 2
        base = n_res;
        start_cfg(32'd0, 32'd10);
        wait_result("ab_0", 32'd0, 64'hC0DE_0000_5A5A_5A5A);
        wait_result("ab_1", 32'd1, 64'hC0DE_0000_5A5A_5A5B);
        n = 0;
        while (!(wrap_bus.region == 32'd2 && wrap_bus.cmd == CMD_START &&
                 wrap_bus.cmd_valid == 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ab_reach_wait", 64'(wrap_bus.region), 64'd2);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'd1);
        chk("ab_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd0);
        wait_result("ab_2", 32'd2, 64'hC0DE_0000_5A5A_5A58);
        wait_idle("ab");
        chk("ab_count", 64'(n_res - base), 64'd3);
        chk("ab_last_region", 64'(wrap_bus.region), 64'd2);

        // Host stall in PUSH
        base = n_res;
        res_ready = 1'b0;
        start_cfg(32'd4, 32'd4);
        wait_result("stall", 32'd4, 64'hC0DE_0000_5A5A_5A5E);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_region !== 32'd4 ||
                res_counter !== 64'hC0DE_0000_5A5A_5A5E ||
                wrap_bus.cmd_valid !== 1'b0) bad++;
        end
        chk("stall_stable", 64'(bad), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'(res_valid), 64'd0);
        wait_idle("stall");
        chk("stall_count", 64'(n_res - base), 64'd1);

        // Wrapper never acknowledges
        e0 = n_err;
        stuck = 1'b1;
        start_cfg(32'd8, 32'd8);
        chk("stuck_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd1);
        chk("stuck_region", 64'(wrap_bus.region), 64'd8);
`ifdef DES_SEQ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("to_err_early", 64'(err), 64'd0);
        chk("to_busy_early", 64'(busy), 64'd1);
        @(negedge clk);
        chk("to_err", 64'(err), 64'd1);
        chk("to_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_cfg_ready", 64'(cfg_ready), 64'd1);
`else
        repeat (40) @(negedge clk);
        chk("nto_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd1);
        chk("nto_busy", 64'(busy), 64'd1);
        chk("nto_no_err", 64'(n_err - e0), 64'd0);
`endif
        stuck = 1'b0;

        // Reset in the middle of a range
        start_cfg(32'd0, 32'd10);
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("mrst_cmd_valid", 64'(wrap_bus.cmd_valid), 64'd0);
        chk("mrst_res_valid", 64'(res_valid), 64'd0);
        chk("mrst_region", 64'(wrap_bus.region), 64'd0);
        chk("mrst_res_counter", res_counter, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_cfg(32'd1, 32'd1);
        wait_result("after_rst", 32'd1, 64'hC0DE_0000_5A5A_5A5B);
        wait_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
